sclk_generator: RTL and testbench

SCLK_GENERATOR -- requirements
Module: sclk_generator

---
 rtl/spi_pkg.sv | 22 ++
 rtl/sclk_tick.sv | 42 ++++
 rtl/sclk_generator.sv | 161 ++++++++++++++++
 tb/tb_sclk_generator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SCLK burst generator: FSM state encodings and
// power-on defaults for the divisor and burst-length registers.
// SCLK_GEN_GAP_EN adds the GAP state (idle spacing after each burst).
package spi_pkg;

`ifdef SCLK_GEN_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1
   } state_t;
`endif

   localparam int P_DEF_DIV = 1;
   localparam int P_DEF_LEN = 8;

endpackage

// File: rtl/sclk_tick.sv
// Half-period counter and SCLK toggle flop. While running, the counter counts
// 0..i_div, and on reaching i_div it wraps and flips SCLK. o_tick is high in
// the cycle before the wrapping edge, so any flop that samples it changes on
// the same edge as SCLK. While not running, SCLK tracks i_idle_lvl and the
// counter is held at zero, so every burst starts from a clean count.
module sclk_tick #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_run,
   input  logic             i_idle_lvl,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick,
   output logic             o_sclk
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_sclk;
   logic             w_wrap;

   assign w_wrap = i_run && (r_cnt == i_div);
   assign o_tick = w_wrap;
   assign o_sclk = r_sclk;

   // Count half-periods and toggle SCLK on wrap; park at idle level otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_run) begin
         r_cnt  <= '0;
         r_sclk <= i_idle_lvl;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/sclk_generator.sv
// SPI-style serial clock burst generator. Produces bursts of i_cfg_len SCLK
// pulses with half-period (div+1) system clocks, plus sample/shift strobes
// that follow the configured CPOL/CPHA.
// Optional build macro: SCLK_GEN_GAP_EN inserts a (div+1)-cycle GAP state
// after each burst before the block returns to IDLE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting; config loads and start requests are accepted
// ST_RUN  | burst in progress; SCLK toggling, config frozen
// ST_GAP  | post-burst spacing, SCLK parked at CPOL (SCLK_GEN_GAP_EN only)
module sclk_generator
   import spi_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int LEN_W   = 6,
   parameter int DEF_DIV = P_DEF_DIV,
   parameter int DEF_LEN = P_DEF_LEN
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cfg_valid,
   input  logic [DIV_W-1:0] i_cfg_div,
   input  logic [LEN_W-1:0] i_cfg_len,
   input  logic             i_cfg_cpol,
   input  logic             i_cfg_cpha,
   input  logic             i_start_n,
   output logic             o_idle,
   output logic             o_sclk,
   output logic             o_sample,
   output logic             o_shift,
   output logic             o_done,
   output logic             o_cfg_err
);

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [LEN_W-1:0] r_len;
   logic             r_cpol;
   logic             r_cpha;
   logic [LEN_W:0]   r_edges;
   logic             r_idle;
   logic             r_sample;
   logic             r_shift;
   logic             r_done;
   logic             r_cfg_err;
`ifdef SCLK_GEN_GAP_EN
   logic [DIV_W-1:0] r_gap_cnt;
`endif

   logic             w_run;
   logic             w_tick;
   logic             w_sclk;
   logic             w_cpol_nxt;
   logic [LEN_W-1:0] w_len_eff;
   logic [LEN_W:0]   w_edges_nxt;
   logic [LEN_W:0]   w_len2;

   assign w_run       = (r_state == ST_RUN);
   // A same-cycle config load must already shape the burst it starts with.
   assign w_cpol_nxt  = (r_state == ST_IDLE && i_cfg_valid) ? i_cfg_cpol : r_cpol;
   assign w_len_eff   = i_cfg_valid ? i_cfg_len : r_len;
   assign w_edges_nxt = r_edges + (LEN_W+1)'(1);
   assign w_len2      = {r_len, 1'b0};

   sclk_tick #(
      .DIV_W      (DIV_W)
   ) u_tick (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_run      (w_run),
      .i_idle_lvl (w_cpol_nxt),
      .i_div      (r_div),
      .o_tick     (w_tick),
      .o_sclk     (w_sclk)
   );

   // Burst sequencing, config register file and registered strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_div     <= DIV_W'(DEF_DIV);
         r_len     <= LEN_W'(DEF_LEN);
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_edges   <= '0;
         r_idle    <= 1'b1;
         r_sample  <= 1'b0;
         r_shift   <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
`ifdef SCLK_GEN_GAP_EN
         r_gap_cnt <= '0;
`endif
      end else begin
         r_sample <= 1'b0;
         r_shift  <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cfg_valid) begin
                  r_div  <= i_cfg_div;
                  r_cpol <= i_cfg_cpol;
                  r_cpha <= i_cfg_cpha;
                  if (i_cfg_len != '0) r_len     <= i_cfg_len;
                  else                 r_cfg_err <= 1'b1;
               end
               if (!i_start_n) begin
                  if (w_len_eff != '0) begin
                     r_state <= ST_RUN;
                     r_idle  <= 1'b0;
                     r_edges <= '0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  r_edges <= w_edges_nxt;
                  // Even r_edges means this toggle is odd-numbered, i.e. leading.
                  if (r_edges[0] == r_cpha) r_sample <= 1'b1;
                  else                      r_shift  <= 1'b1;
                  if (w_edges_nxt == w_len2) begin
                     r_done  <= 1'b1;
`ifdef SCLK_GEN_GAP_EN
                     r_state   <= ST_GAP;
                     r_gap_cnt <= '0;
`else
                     r_state <= ST_IDLE;
                     r_idle  <= 1'b1;
`endif
                  end
               end
            end
`ifdef SCLK_GEN_GAP_EN
            ST_GAP: begin
               if (r_gap_cnt == r_div) begin
                  r_state <= ST_IDLE;
                  r_idle  <= 1'b1;
               end else begin
                  r_gap_cnt <= r_gap_cnt + DIV_W'(1);
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   assign o_idle    = r_idle;
   assign o_sclk    = w_sclk;
   assign o_sample  = r_sample;
   assign o_shift   = r_shift;
   assign o_done    = r_done;
   assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_sclk_generator.sv
// Self-checking bench for sclk_generator. The reference model describes each
// burst by its start cycle and the elapsed-time arithmetic of the protocol
// (toggle k at k*(div+1) cycles, leading edges odd, burst done at 2*len).
module tb_sclk_generator;

   localparam int DIV_W = 8;
   localparam int LEN_W = 6;
`ifdef SCLK_GEN_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_cfg_valid = 1'b0;
   logic [DIV_W-1:0] i_cfg_div = '0;
   logic [LEN_W-1:0] i_cfg_len = '0;
   logic             i_cfg_cpol = 1'b0;
   logic             i_cfg_cpha = 1'b0;
   logic             i_start_n = 1'b1;
   logic             o_idle, o_sclk, o_sample, o_shift, o_done, o_cfg_err;

   always #5 i_clk = ~i_clk;

   sclk_generator #(
      .DIV_W       (DIV_W),
      .LEN_W       (LEN_W),
      .DEF_DIV     (1),
      .DEF_LEN     (8)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cfg_valid (i_cfg_valid),
      .i_cfg_div   (i_cfg_div),
      .i_cfg_len   (i_cfg_len),
      .i_cfg_cpol  (i_cfg_cpol),
      .i_cfg_cpha  (i_cfg_cpha),
      .i_start_n   (i_start_n),
      .o_idle      (o_idle),
      .o_sclk      (o_sclk),
      .o_sample    (o_sample),
      .o_shift     (o_shift),
      .o_done      (o_done),
      .o_cfg_err   (o_cfg_err)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state
   int m_div, m_len, m_e0, m_ret;
   bit m_cpol, m_cpha, m_err, m_busy;

   // observation counters
   int n_samp, n_done, n_tog, t_first;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_div  = 1;
      m_len  = 8;
      m_cpol = 1'b0;
      m_cpha = 1'b0;
      m_err  = 1'b0;
      m_busy = 1'b0;
   endfunction

   function automatic bit model_idle();
      return !m_busy || ((cyc - m_e0) >= m_ret);
   endfunction

   function automatic void clear_obs();
      n_samp  = 0;
      n_done  = 0;
      n_tog   = 0;
      t_first = -1;
   endfunction

   task automatic check_outputs();
      int e, per, k;
      bit ex_sclk, ex_idle, ex_samp, ex_shift, ex_done;
      ex_sclk  = m_cpol;
      ex_idle  = 1'b1;
      ex_samp  = 1'b0;
      ex_shift = 1'b0;
      ex_done  = 1'b0;
      if (m_busy) begin
         e   = cyc - m_e0;
         per = m_div + 1;
         if (e <= m_ret) begin
            ex_idle = (e == m_ret);
            if (e <= 2 * m_len * per) begin
               k = e / per;
               ex_sclk = m_cpol ^ k[0];
               if (e != 0 && (e % per) == 0) begin
                  if ((k % 2 == 1) == (m_cpha == 1'b0)) ex_samp  = 1'b1;
                  else                                  ex_shift = 1'b1;
                  ex_done = (k == 2 * m_len);
               end
            end
         end else begin
            m_busy = 1'b0;
         end
      end
      check_eq("sclk",    o_sclk,    ex_sclk);
      check_eq("idle",    o_idle,    ex_idle);
      check_eq("sample",  o_sample,  ex_samp);
      check_eq("shift",   o_shift,   ex_shift);
      check_eq("done",    o_done,    ex_done);
      check_eq("cfg_err", o_cfg_err, m_err);
      if (o_sample === 1'b1) n_samp++;
      if (o_done === 1'b1)   n_done++;
      if (o_sample === 1'b1 || o_shift === 1'b1) begin
         n_tog++;
         if (t_first < 0) t_first = cyc;
      end
   endtask

   // Drive one cycle of inputs (called at a falling edge), predict, then check.
   task automatic step(input bit v, input int div, input int len,
                       input bit cp, input bit ch, input bit st_n);
      int eff;
      i_cfg_valid = v;
      i_cfg_div   = DIV_W'(div);
      i_cfg_len   = LEN_W'(len);
      i_cfg_cpol  = cp;
      i_cfg_cpha  = ch;
      i_start_n   = st_n;
      if (model_idle()) begin
         m_busy = 1'b0;
         eff = v ? len : m_len;
         if (v) begin
            m_div  = div;
            m_cpol = cp;
            m_cpha = ch;
            if (len != 0) m_len = len;
            else          m_err = 1'b1;
         end
         if (!st_n) begin
            if (eff != 0) begin
               m_busy = 1'b1;
               m_e0   = cyc + 1;
               m_ret  = 2 * m_len * (m_div + 1) + (GAP ? (m_div + 1) : 0);
            end else begin
               m_err = 1'b1;
            end
         end
      end
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
      check_outputs();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      i_cfg_valid = 1'b0;
      i_start_n   = 1'b1;
      i_rst_n     = 1'b0;
      #1;
      check_eq("rst_sclk",    o_sclk,    1'b0);
      check_eq("rst_idle",    o_idle,    1'b1);
      check_eq("rst_sample",  o_sample,  1'b0);
      check_eq("rst_shift",   o_shift,   1'b0);
      check_eq("rst_done",    o_done,    1'b0);
      check_eq("rst_cfg_err", o_cfg_err, 1'b0);
      model_reset();
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      int len, r;
      bit v, st_n;
      model_reset();
      clear_obs();
      @(negedge i_clk);
      do_reset();
      idle_steps(3);

      // div=0 len=8 mode 0, config and start in the same cycle
      clear_obs();
      step(1'b1, 0, 8, 1'b0, 1'b0, 1'b0);
      idle_steps(24);
      check_eq("m0_samples", n_samp, 8);
      check_eq("m0_toggles", n_tog, 16);
      check_eq("m0_done",    n_done, 1);

      // div=3 len=2 mode 3: idle high, first toggle 4 cycles after entry
      step(1'b1, 3, 2, 1'b1, 1'b1, 1'b1);
      idle_steps(2);
      clear_obs();
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      r = cyc;
      idle_steps(24);
      check_eq("m3_first_toggle", t_first - r, 4);
      check_eq("m3_samples",      n_samp, 2);
      check_eq("m3_done",         n_done, 1);

      // length 0 with a start in the same cycle: rejected, error sticks
      clear_obs();
      step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
      idle_steps(6);
      check_eq("len0_toggles", n_tog, 0);
      check_eq("len0_err",     o_cfg_err, 1'b1);

      // config during RUN is ignored for this and the next burst
      step(1'b1, 1, 3, 1'b0, 1'b0, 1'b0);
      idle_steps(2);
      step(1'b1, 5, 7, 1'b1, 1'b1, 1'b1);
      idle_steps(14);
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      idle_steps(16);

      // reset at the 5th toggle aborts the burst with no done
      step(1'b1, 1, 8, 1'b0, 1'b0, 1'b0);
      clear_obs();
      for (int i = 0; i < 200 && n_tog < 5; i++) idle_steps(1);
      check_eq("tog5_reached", n_tog >= 5, 1'b1);
      do_reset();
      clear_obs();
      idle_steps(20);
      check_eq("abort_no_done", n_done, 0);

      // back-to-back bursts with start held low
      step(1'b1, 2, 2, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 80; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      idle_steps(20);

      // randomized traffic, with one reset midway
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         v = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 19);
         if (r == 0)      len = 0;
         else if (r == 1) len = 63;
         else             len = $urandom_range(1, 6);
         st_n = ($urandom_range(0, 2) != 0);
         step(v, $urandom_range(0, 4), len, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), st_n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
